// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - state encoding and timeout sizing for the stage sequencer
package cpu_seq_pkg;

    localparam int TIMEOUT_DEF = 255;
    localparam int TIMEOUT_W   = $clog2(TIMEOUT_DEF + 1);

    typedef enum logic [2:0] {
        S_IF_REQ   = 3'd0,
        S_IF_WAIT  = 3'd1,
        S_EX       = 3'd2,
        S_MEM_REQ  = 3'd3,
        S_MEM_WAIT = 3'd4,
        S_WB       = 3'd5,
        S_HALT     = 3'd6,
        S_ERR      = 3'd7
    } seq_state_t;

    function automatic int timeout_w(input int t);
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// rtl/seq_timeout_cnt.sv - per-state bus wait counter with expiry flag
module seq_timeout_cnt #(
    parameter int TIMEOUT = 255,
    parameter int W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // expired flags the TIMEOUT-th cycle spent in the current bus state
    assign expired = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_stage_seq.sv
// rtl/cpu_stage_seq.sv - multi-cycle fetch/execute/memory/writeback sequencer
module cpu_stage_seq
    import cpu_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    output logic             dmem_req_wr,
    input  logic             dmem_rsp_valid,
    input  logic [31:0]      dmem_rsp_data,
    input  logic             dec_memtoreg,
    input  logic             dec_memwr,
    input  logic             dec_regwr,
    input  logic             dec_halt,
    output logic [31:0]      inst_o,
    output logic [31:0]      ld_data_o,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halted_o,
    output logic             err_o,
    output logic             err_is_dmem,
    output logic [CNT_W-1:0] retired_o
);

    localparam int TW = timeout_w(TIMEOUT);

    seq_state_t state;
    seq_state_t nstate;
    logic       tmo_en;
    logic       tmo_clr;
    logic       expired;

    assign tmo_en  = (state == S_IF_REQ) || (state == S_IF_WAIT) ||
                     (state == S_MEM_REQ) || (state == S_MEM_WAIT);
    assign tmo_clr = (nstate != state);

    seq_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .W       (TW)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (expired)
    );

    // the exit event is tested before expiry so a coincident response wins
    always_comb begin
        nstate = state;
        case (state)
            S_IF_REQ:   if (imem_req_ready) nstate = S_IF_WAIT;
                        else if (expired)   nstate = S_ERR;
            S_IF_WAIT:  if (imem_rsp_valid) nstate = S_EX;
                        else if (expired)   nstate = S_ERR;
            S_EX:       if (dec_halt)                      nstate = S_HALT;
                        else if (dec_memtoreg | dec_memwr) nstate = S_MEM_REQ;
                        else                               nstate = S_WB;
            S_MEM_REQ:  if (dmem_req_ready) nstate = S_MEM_WAIT;
                        else if (expired)   nstate = S_ERR;
            S_MEM_WAIT: if (dmem_rsp_valid) nstate = S_WB;
                        else if (expired)   nstate = S_ERR;
            S_WB:       nstate = S_IF_REQ;
            default:    nstate = state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IF_REQ;
            inst_o      <= '0;
            ld_data_o   <= '0;
            retired_o   <= '0;
            err_is_dmem <= 1'b0;
        end else begin
            state <= nstate;
            if (state == S_IF_WAIT && imem_rsp_valid) begin
                inst_o <= imem_rsp_data;
            end
            if (state == S_MEM_WAIT && dmem_rsp_valid && dec_memtoreg) begin
                ld_data_o <= dmem_rsp_data;
            end
            if (state == S_WB) begin
                retired_o <= retired_o + 1'b1;
            end
            if (nstate == S_ERR && state != S_ERR) begin
                err_is_dmem <= (state == S_MEM_REQ) || (state == S_MEM_WAIT);
            end
        end
    end

    // reset state is IF_REQ, but no fetch may be presented while rst is held
    assign imem_req_valid = (state == S_IF_REQ) && !rst;
    assign dmem_req_valid = (state == S_MEM_REQ);
    assign dmem_req_wr    = (state == S_MEM_REQ) && dec_memwr;
    assign pc_we          = (state == S_WB);
    assign rf_we          = (state == S_WB) && dec_regwr;
    assign halted_o       = (state == S_HALT);
    assign err_o          = (state == S_ERR);

endmodule

// File: tb/tb_cpu_stage_seq.sv
// tb/tb_cpu_stage_seq.sv - directed self-checking bench for cpu_stage_seq
module tb_cpu_stage_seq;

    localparam int TO = 8;
    localparam int CW = 64;
    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_HALT = 3;
    localparam logic [31:0] ADDI   = 32'h0050_0093;
    localparam logic [31:0] LW     = 32'h0000_A103;
    localparam logic [31:0] SW     = 32'h0020_A223;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          dmem_req_valid, dmem_req_ready, dmem_req_wr, dmem_rsp_valid;
    logic [31:0]   dmem_rsp_data;
    logic          dec_memtoreg, dec_memwr, dec_regwr, dec_halt;
    logic [31:0]   inst_o, ld_data_o;
    logic          pc_we, rf_we, halted_o, err_o, err_is_dmem;
    logic [CW-1:0] retired_o;

    always #5 clk = ~clk;

    cpu_stage_seq #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_wr(dmem_req_wr), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rsp_data(dmem_rsp_data),
        .dec_memtoreg(dec_memtoreg), .dec_memwr(dec_memwr),
        .dec_regwr(dec_regwr), .dec_halt(dec_halt),
        .inst_o(inst_o), .ld_data_o(ld_data_o), .pc_we(pc_we), .rf_we(rf_we),
        .halted_o(halted_o), .err_o(err_o), .err_is_dmem(err_is_dmem),
        .retired_o(retired_o)
    );

    // stand-in for the combinational decoder, driven from the DUT's IR
    always_comb begin
        dec_memtoreg = (inst_o[6:0] == 7'h03);
        dec_memwr    = (inst_o[6:0] == 7'h23);
        dec_regwr    = (inst_o[6:0] == 7'h03) || (inst_o[6:0] == 7'h13);
        dec_halt     = (inst_o == EBREAK);
    end

    int          checks = 0;
    int          errors = 0;
    bit          e_ireq, e_dreq, e_wr, e_pc, e_rf, e_halt, e_err, e_errd;
    logic [31:0] m_inst, m_ld;
    logic [63:0] m_ret;
    bit          spur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_exp(input bit ireq, dreq, wr, pc, rf, halt, err, errd);
        e_ireq = ireq; e_dreq = dreq; e_wr = wr; e_pc = pc;
        e_rf = rf; e_halt = halt; e_err = err; e_errd = errd;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_req_valid"}, imem_req_valid, e_ireq);
        chk({tag, ".dmem_req_valid"}, dmem_req_valid, e_dreq);
        chk({tag, ".dmem_req_wr"},    dmem_req_wr,    e_wr);
        chk({tag, ".pc_we"},          pc_we,          e_pc);
        chk({tag, ".rf_we"},          rf_we,          e_rf);
        chk({tag, ".halted_o"},       halted_o,       e_halt);
        chk({tag, ".err_o"},          err_o,          e_err);
        chk({tag, ".err_is_dmem"},    err_is_dmem,    e_errd);
        chk({tag, ".inst_o"},         inst_o,         m_inst);
        chk({tag, ".ld_data_o"},      ld_data_o,      m_ld);
        chk({tag, ".retired_o"},      retired_o,      m_ret);
    endtask

    // one clock: drive at the falling edge, compare 1 ns later, advance to the next falling edge
    task automatic cyc(input bit ir, iv, input logic [31:0] id, input bit dr, dv, input logic [31:0] dd);
        imem_req_ready = ir;
        imem_rsp_valid = iv;
        imem_rsp_data  = id;
        dmem_req_ready = dr;
        dmem_rsp_valid = dv | spur;
        dmem_rsp_data  = spur ? 32'hBAD0_BAD0 : dd;
        spur = 1'b0;
        #1;
        check_all("cyc");
        @(negedge clk);
    endtask

    task automatic do_reset();
        imem_req_ready = 0; imem_rsp_valid = 0; dmem_req_ready = 0; dmem_rsp_valid = 0;
        #2 rst = 1'b1;
        m_inst = '0; m_ld = '0; m_ret = '0;
        set_exp(0, 0, 0, 0, 0, 0, 0, 0);
        #1 check_all("rst_now");
        @(negedge clk);
        check_all("rst_held");
        rst = 1'b0;
    endtask

    // one bus state: the event (ready/response) lands on cycle d; d >= TO means it never comes in time
    task automatic bus_phase(input bit dport, input bit req, input int d, input logic [31:0] data,
                             input bit wr, output int n, output bit to);
        bit ev;
        to = (d + 1 > TO);
        n  = to ? TO : d + 1;
        for (int k = 0; k < n; k++) begin
            ev = (k == d);
            set_exp(!dport && req, dport && req, dport && req && wr, 0, 0, 0, 0, 0);
            cyc(!dport && req && ev, !dport && !req && ev, data, dport && req && ev, dport && !req && ev, data);
        end
    endtask

    task automatic err_phase(input bit dport);
        set_exp(0, 0, 0, 0, 0, 0, 1, dport);
        repeat (4) cyc(1, 1, 32'h0, 1, 1, 32'h0);
        do_reset();
    endtask

    task automatic run_instr(input logic [31:0] ins, input int kind, input int ireq, irsp, dreq, drsp,
                             input logic [31:0] ldv, input int lit_total, input bit abort);
        int n, total;
        bit to;
        total = 0;
        bus_phase(0, 1, ireq, ins, 0, n, to); total += n;
        if (to) begin err_phase(0); return; end
        bus_phase(0, 0, irsp, ins, 0, n, to); total += n;
        if (to) begin err_phase(0); return; end
        m_inst = ins;
        set_exp(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); total++;
        if (kind == K_HALT) begin
            set_exp(0, 0, 0, 0, 0, 1, 0, 0);
            repeat (20) cyc(1, 0, 32'h0, 1, 0, 32'h0);
            do_reset();
            return;
        end
        if (kind == K_LD || kind == K_ST) begin
            bus_phase(1, 1, dreq, ldv, kind == K_ST, n, to); total += n;
            if (to) begin err_phase(1); return; end
            if (abort) begin
                set_exp(0, 0, 0, 0, 0, 0, 0, 0);
                cyc(0, 0, 0, 0, 0, 0);
                do_reset();
                return;
            end
            bus_phase(1, 0, drsp, ldv, 0, n, to); total += n;
            if (to) begin err_phase(1); return; end
            if (kind == K_LD) m_ld = ldv;
        end
        set_exp(0, 0, 0, 1, kind != K_ST, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0); total++;
        m_ret = m_ret + 1;
        if (lit_total > 0) chk("total_cycles", total, lit_total);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_data = '0;
        spur = 0; m_inst = '0; m_ld = '0; m_ret = '0;
        set_exp(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        run_instr(ADDI, K_ALU, 0, 0, 0, 0, 32'h0, 4, 0);
        chk("t1_retired", retired_o, 64'd1);

        run_instr(LW, K_LD, 0, 0, 0, 3, 32'hDEAD_BEEF, 9, 0);
        chk("t2_ld_data", ld_data_o, 64'hDEAD_BEEF);

        run_instr(SW, K_ST, 0, 0, 0, 0, 32'h1234_5678, 6, 0);
        chk("t3_ld_data_held", ld_data_o, 64'hDEAD_BEEF);
        run_instr(ADDI, K_ALU, 2, 1, 0, 0, 32'h0, 7, 0);
        run_instr(LW, K_LD, 1, 2, 2, 1, 32'h0F0F_A5A5, 12, 0);
        chk("bp_retired", retired_o, 64'd5);

        run_instr(ADDI, K_ALU, 99, 0, 0, 0, 32'h0, 0, 0);
        run_instr(LW, K_LD, 0, 0, 0, 99, 32'h0, 0, 0);
        run_instr(SW, K_ST, 0, 0, 99, 0, 32'h0, 0, 0);
        run_instr(ADDI, K_ALU, 0, 7, 0, 0, 32'h0, 11, 0);
        run_instr(LW, K_LD, 7, 0, 0, 7, 32'hCAFE_F00D, 20, 0);

        run_instr(EBREAK, K_HALT, 0, 0, 0, 0, 32'h0, 0, 0);
        run_instr(ADDI, K_ALU, 0, 0, 0, 0, 32'h0, 4, 0);

        run_instr(LW, K_LD, 0, 0, 0, 3, 32'h5555_AAAA, 0, 1);
        spur = 1'b1;
        run_instr(ADDI, K_ALU, 0, 0, 0, 0, 32'h0, 4, 0);
        chk("t6_ld_after_late_rsp", ld_data_o, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
